// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: FSM encodings, reset patterns
// and small pure helpers for row/column decoding. The bus-decode block reads
// the status register as {overrun, key_valid, keycode}.
package keypad_scanner_pkg;

    // Scanner FSM states; encodings are fixed because the bus-decode block decodes them
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    localparam logic [3:0] ROWS_RESET = 4'b1110;
    localparam logic [3:0] COLS_IDLE  = 4'b1111;

    // Status register field positions within {overrun, key_valid, keycode}
    localparam int STATUS_W       = 6;
    localparam int STATUS_OVR_BIT = 5;
    localparam int STATUS_VLD_BIT = 4;

    // Position of the single low bit in a one-cold row drive
    function automatic logic [1:0] row_index(input logic [3:0] rows_v);
        logic [1:0] idx_v;
        case (rows_v)
            4'b1110: idx_v = 2'd0;
            4'b1101: idx_v = 2'd1;
            4'b1011: idx_v = 2'd2;
            4'b0111: idx_v = 2'd3;
            default: idx_v = 2'd0;
        endcase
        return idx_v;
    endfunction

    // Lowest-numbered low column; only meaningful when at least one column is low
    function automatic logic [1:0] low_col_index(input logic [3:0] cs_v);
        logic [1:0] idx_v;
        if (cs_v[0] == 1'b0) begin
            idx_v = 2'd0;
        end else if (cs_v[1] == 1'b0) begin
            idx_v = 2'd1;
        end else if (cs_v[2] == 1'b0) begin
            idx_v = 2'd2;
        end else begin
            idx_v = 2'd3;
        end
        return idx_v;
    endfunction

    // Advance the one-cold row drive to the next row: 1110->1101->1011->0111->1110
    function automatic logic [3:0] rotate_rows(input logic [3:0] rows_v);
        return {rows_v[2:0], rows_v[3]};
    endfunction

    // Pack the CPU-visible status word
    function automatic logic [STATUS_W-1:0] pack_status(input logic       overrun_v,
                                                        input logic       key_valid_v,
                                                        input logic [3:0] keycode_v);
        return {overrun_v, key_valid_v, keycode_v};
    endfunction

endpackage

// File: rtl/keypad_scanner_checker.sv
// Property checker for the keypad scanner outputs. Kept outside the design so
// the synthesizable RTL carries no assertions.
module keypad_scanner_checker (
    input logic       clk,
    input logic       rst,
    input logic [3:0] rows,
    input logic       key_valid,
    input logic       overrun
);

    // The row drive must always have exactly one low bit
    rows_one_cold_a : assert property (@(posedge clk) disable iff (rst) $onehot(~rows));

    // Overrun can only be pending alongside a pending key
    overrun_needs_valid_a : assert property (@(posedge clk) disable iff (rst) overrun |-> key_valid);

endmodule

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running divider that produces a one-cycle tick whenever the divider
// sits at all-ones. The tick is registered so it is glitch-free and can be
// shared with the 7-segment refresh logic.
module scan_tick_gen #(
    parameter int SCAN_DIV_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE      = SCAN_DIV_BITS'(1);
    localparam logic [SCAN_DIV_BITS-1:0] DIV_ALL_ONES = {SCAN_DIV_BITS{1'b1}};

    logic [SCAN_DIV_BITS-1:0] div_r;
    logic [SCAN_DIV_BITS-1:0] div_nxt_s;
    logic                     tick_r;

    // Next divider value; wraps naturally from all-ones back to zero
    always_comb begin
        div_nxt_s = div_r + DIV_ONE;
    end

    // Divider and registered tick that is high exactly while div_r is all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r  <= {SCAN_DIV_BITS{1'b0}};
            tick_r <= 1'b0;
        end else begin
            div_r  <= div_nxt_s;
            tick_r <= (div_nxt_s == DIV_ALL_ONES);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, synchronizes the
// column inputs, debounces presses and releases, and latches a key code into
// a sticky CPU-visible register cleared by a one-cycle ack.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols,
    input  logic       ack,
    output logic [3:0] rows,
    output logic [3:0] keycode,
    output logic       key_valid,
    output logic       overrun
);

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_TICKS);

    logic       tick_s;
    logic [3:0] cols_meta_r;
    logic [3:0] cs_r;
    kp_state_e  state_r;
    logic [3:0] rows_r;
    logic [3:0] deb_cnt_r;
    logic [1:0] cap_row_r;
    logic [1:0] cap_col_r;
    logic [3:0] keycode_r;
    logic       key_valid_r;
    logic       overrun_r;

    logic       all_high_s;
    logic       cap_col_low_s;
    logic [3:0] deb_inc_s;
    logic       deb_done_s;

    scan_tick_gen #(
        .SCAN_DIV_BITS(SCAN_DIV_BITS)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick_s)
    );

    // Two-flop synchronizer for the asynchronous column inputs; idles high like the pull-ups
    always_ff @(posedge clk) begin
        if (rst) begin
            cols_meta_r <= COLS_IDLE;
            cs_r        <= COLS_IDLE;
        end else begin
            cols_meta_r <= cols;
            cs_r        <= cols_meta_r;
        end
    end

    // Column status and saturating debounce increment used by the FSM
    always_comb begin
        all_high_s    = (cs_r == COLS_IDLE);
        cap_col_low_s = (cs_r[cap_col_r] == 1'b0);
        if (deb_cnt_r >= DEB_TARGET) begin
            deb_inc_s = DEB_TARGET;
        end else begin
            deb_inc_s = deb_cnt_r + 4'd1;
        end
        deb_done_s = (deb_inc_s >= DEB_TARGET);
    end

    // Scan/debounce FSM with the sticky key register; a latch overrides a same-cycle ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SCAN;
            rows_r      <= ROWS_RESET;
            deb_cnt_r   <= 4'd0;
            cap_row_r   <= 2'd0;
            cap_col_r   <= 2'd0;
            keycode_r   <= 4'd0;
            key_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (ack) begin
                key_valid_r <= 1'b0;
                overrun_r   <= 1'b0;
            end
            if (tick_s) begin
                case (state_r)
                    SCAN: begin
                        if (all_high_s) begin
                            rows_r <= rotate_rows(rows_r);
                        end else begin
                            cap_row_r <= row_index(rows_r);
                            cap_col_r <= low_col_index(cs_r);
                            deb_cnt_r <= 4'd1;
                            state_r   <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (!cap_col_low_s) begin
                            // Bounce: give up on this key and carry on scanning
                            deb_cnt_r <= 4'd0;
                            rows_r    <= rotate_rows(rows_r);
                            state_r   <= SCAN;
                        end else if (deb_done_s) begin
                            keycode_r   <= {cap_row_r, cap_col_r};
                            key_valid_r <= 1'b1;
                            overrun_r   <= ack ? 1'b0 : (overrun_r | key_valid_r);
                            deb_cnt_r   <= 4'd0;
                            state_r     <= HELD;
                        end else begin
                            deb_cnt_r <= deb_inc_s;
                        end
                    end
                    HELD: begin
                        // Wait for a clean release so a held key latches only once
                        if (!all_high_s) begin
                            deb_cnt_r <= 4'd0;
                        end else if (deb_done_s) begin
                            deb_cnt_r <= 4'd0;
                            rows_r    <= rotate_rows(rows_r);
                            state_r   <= SCAN;
                        end else begin
                            deb_cnt_r <= deb_inc_s;
                        end
                    end
                    default: begin
                        state_r   <= SCAN;
                        rows_r    <= ROWS_RESET;
                        deb_cnt_r <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign rows      = rows_r;
    assign keycode   = keycode_r;
    assign key_valid = key_valid_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a fast scan
// (SCAN_DIV_BITS=2 -> tick every 4 clk) and DEBOUNCE_TICKS=2.
// The keypad model shorts the pressed key's row to its column.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic       ack;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] keycode;
    logic       key_valid;
    logic       overrun;

    logic       pressed;
    logic [1:0] pr;
    logic [1:0] pc;

    int vectors     = 0;
    int miscompares = 0;

    keypad_scanner #(
        .SCAN_DIV_BITS (2),
        .DEBOUNCE_TICKS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cols     (cols),
        .ack      (ack),
        .rows     (rows),
        .keycode  (keycode),
        .key_valid(key_valid),
        .overrun  (overrun)
    );

    keypad_scanner_checker u_chk (
        .clk      (clk),
        .rst      (rst),
        .rows     (rows),
        .key_valid(key_valid),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model: the pressed column follows its row when that row is driven low
    always_comb begin
        cols = 4'hF;
        if (pressed && (rows[pr] == 1'b0)) cols[pc] = 1'b0;
    end

    task automatic press_key(input int r, input int c);
        pr      = r[1:0];
        pc      = c[1:0];
        pressed = 1'b1;
    endtask

    task automatic release_key();
        pressed = 1'b0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic wait_for_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (key_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_for_overrun(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (overrun === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Returns at the first negedge where rows has just switched to target
    task automatic wait_rows_edge(input logic [3:0] target, output bit ok);
        logic [3:0] prev;
        ok   = 1'b0;
        prev = rows;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rows === target && prev !== target) begin
                ok = 1'b1;
                break;
            end
            prev = rows;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_rows;
        rst = 1'b1; ack = 1'b0; pressed = 1'b0; pr = 2'd0; pc = 2'd0;
        repeat (3) @(negedge clk);
        vectors++; if (rows !== 4'b1110) begin miscompares++; $display("FAIL reset_rows actual=%b required=1110", rows); end
        vectors++; if (keycode !== 4'h0) begin miscompares++; $display("FAIL reset_keycode actual=%h required=0", keycode); end
        vectors++; if (key_valid !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL reset_flags actual=%b%b required=00", key_valid, overrun); end
        rst = 1'b0;
        exp_rows = 4'b1110;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k % 4 == 0) exp_rows = {exp_rows[2:0], exp_rows[3]};
            vectors++;
            if (rows !== exp_rows || key_valid !== 1'b0 || overrun !== 1'b0) begin
                miscompares++;
                $display("FAIL rotate_cycle%0d actual rows=%b v=%b o=%b required rows=%b v=0 o=0", k, rows, key_valid, overrun, exp_rows);
            end
        end
        ack_pulse();
        vectors++; if (key_valid !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL ack_idle actual=%b%b required=00", key_valid, overrun); end
    endtask

    task automatic test_hold();
        bit ok;
        int bad;
        press_key(2, 1);
        wait_for_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL hold_latch actual=timeout required=key_valid"); end
        vectors++; if (keycode !== 4'h9) begin miscompares++; $display("FAIL hold_keycode actual=%h required=9", keycode); end
        vectors++; if (rows !== 4'b1011) begin miscompares++; $display("FAIL hold_rows actual=%b required=1011", rows); end
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rows !== 4'b1011 || keycode !== 4'h9 || key_valid !== 1'b1 || overrun !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL hold_no_repeat actual=%0d bad cycles required=0", bad); end
        release_key();
        repeat (24) @(negedge clk);
        ack_pulse();
        vectors++; if (key_valid !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL hold_ack actual=%b%b required=00", key_valid, overrun); end
        vectors++; if (keycode !== 4'h9) begin miscompares++; $display("FAIL hold_code_kept actual=%h required=9", keycode); end
    endtask

    task automatic test_bounce();
        bit ok;
        wait_rows_edge(4'b1110, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bounce_align actual=timeout required=rows 1110"); end
        press_key(0, 3);
        repeat (4) @(negedge clk);
        vectors++; if (rows !== 4'b1110) begin miscompares++; $display("FAIL bounce_frozen actual=%b required=1110", rows); end
        release_key();
        repeat (4) @(negedge clk);
        vectors++; if (rows !== 4'b1101) begin miscompares++; $display("FAIL bounce_resume actual=%b required=1101", rows); end
        repeat (40) @(negedge clk);
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL bounce_no_latch actual=%b required=0", key_valid); end
    endtask

    task automatic test_overrun();
        bit ok;
        press_key(1, 1);
        wait_for_valid(ok);
        vectors++; if (!ok || keycode !== 4'h5) begin miscompares++; $display("FAIL ovr_first actual=ok%0d code=%h required=ok1 code=5", ok, keycode); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_first_flag actual=%b required=0", overrun); end
        release_key();
        repeat (24) @(negedge clk);
        press_key(1, 2);
        wait_for_overrun(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ovr_set actual=timeout required=overrun"); end
        vectors++; if (keycode !== 4'h6 || key_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_second actual=%h/%b required=6/1", keycode, key_valid); end
        release_key();
        repeat (24) @(negedge clk);
        ack_pulse();
        vectors++; if (key_valid !== 1'b0 || overrun !== 1'b0 || keycode !== 4'h6) begin miscompares++; $display("FAIL ovr_ack actual=%b%b/%h required=00/6", key_valid, overrun, keycode); end
    endtask

    task automatic test_ack_with_latch();
        bit ok;
        press_key(3, 0);
        wait_for_valid(ok);
        vectors++; if (!ok || keycode !== 4'hC) begin miscompares++; $display("FAIL same_pre actual=ok%0d code=%h required=ok1 code=c", ok, keycode); end
        release_key();
        wait_rows_edge(4'b1110, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL same_align actual=timeout required=rows 1110"); end
        press_key(0, 3);
        repeat (7) @(negedge clk);
        vectors++; if (key_valid !== 1'b1 || keycode !== 4'hC || overrun !== 1'b0) begin miscompares++; $display("FAIL same_before actual=%b%b/%h required=10/c", key_valid, overrun, keycode); end
        ack_pulse();
        vectors++; if (key_valid !== 1'b1 || keycode !== 4'h3 || overrun !== 1'b0) begin miscompares++; $display("FAIL same_cycle actual=v%b o%b code=%h required=v1 o0 code=3", key_valid, overrun, keycode); end
        release_key();
        repeat (24) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_rows_edge(4'b1101, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rmid_align actual=timeout required=rows 1101"); end
        press_key(1, 0);
        repeat (5) @(negedge clk);
        vectors++; if (rows !== 4'b1101) begin miscompares++; $display("FAIL rmid_debounce actual=%b required=1101", rows); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (rows !== 4'b1110 || key_valid !== 1'b0 || overrun !== 1'b0 || keycode !== 4'h0) begin
            miscompares++;
            $display("FAIL rmid_reset actual=%b %b%b %h required=1110 00 0", rows, key_valid, overrun, keycode);
        end
        wait_for_valid(ok);
        vectors++; if (!ok || keycode !== 4'h4 || rows !== 4'b1101) begin miscompares++; $display("FAIL rmid_relatch actual=ok%0d code=%h rows=%b required=ok1 code=4 rows=1101", ok, keycode, rows); end
        release_key();
        repeat (24) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_hold();
        test_bounce();
        test_overrun();
        test_ack_with_latch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
